// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-port data-memory arbiter: requester ports A/B and the memory side.
interface dmem_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Port A
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_err;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  // Port B
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_err;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  // Data memory side
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  // Arbiter view
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_err, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_err, b_rvalid, b_rdata,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data
  );

  // Requesters plus memory view
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_err, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_err, b_rvalid, b_rdata,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one combinational-read data memory between ports A and B.
// Each transaction takes an IDLE sample cycle and an ACCESS cycle; reads return one cycle later.
module dmem_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_prio;
  logic          r_cmd_port;
  logic          r_cmd_we;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;

  logic          r_a_gnt;
  logic          r_a_err;
  logic          r_a_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic          r_b_gnt;
  logic          r_b_err;
  logic          r_b_rvalid;
  logic [DW-1:0] r_b_rdata;

  logic          w_any_req;
  logic          w_win_port;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  logic          w_win_misaligned;
  logic          w_grant;
  logic          w_cmd_aligned;
  logic          w_mem_go;
  logic          w_rd_done;

  // Pick the winner: a lone requester wins, otherwise the port holding priority
  always_comb begin
    w_any_req  = bus.a_req | bus.b_req;
    w_win_port = r_prio;
    if (bus.a_req && !bus.b_req) begin
      w_win_port = PORT_A;
    end else if (bus.b_req && !bus.a_req) begin
      w_win_port = PORT_B;
    end
    w_win_we         = (w_win_port == PORT_A) ? bus.a_we    : bus.b_we;
    w_win_addr       = (w_win_port == PORT_A) ? bus.a_addr  : bus.b_addr;
    w_win_wdata      = (w_win_port == PORT_A) ? bus.a_wdata : bus.b_wdata;
    w_win_misaligned = (w_win_addr[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a grant is issued on every IDLE->ACCESS transition
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_ACCESS;
          w_grant     = 1'b1;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command registers and round-robin pointer, loaded on grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= RESET_PRIO;
      r_cmd_port  <= PORT_A;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else if (w_grant) begin
      r_prio      <= ~w_win_port;
      r_cmd_port  <= w_win_port;
      r_cmd_we    <= w_win_we;
      r_cmd_addr  <= w_win_addr;
      r_cmd_wdata <= w_win_wdata;
    end
  end

  // Memory strobes fire only for an aligned command in ACCESS and are killed by reset at once
  always_comb begin
    w_cmd_aligned = (r_cmd_addr[1:0] == 2'b00);
    w_mem_go      = (r_state == S_ACCESS) && w_cmd_aligned && !reset;
    w_rd_done     = w_mem_go && !r_cmd_we;
  end

  assign bus.mem_addr    = r_cmd_addr;
  assign bus.mem_wr_data = r_cmd_wdata;
  assign bus.mem_rd_en   = w_mem_go && !r_cmd_we;
  assign bus.mem_wr_en   = w_mem_go && r_cmd_we;

  // Per-port grant/error pulses aligned with ACCESS, read data captured at the end of ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_gnt    <= 1'b0;
      r_a_err    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_gnt    <= 1'b0;
      r_b_err    <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= '0;
    end else begin
      r_a_gnt    <= w_grant && (w_win_port == PORT_A);
      r_a_err    <= w_grant && (w_win_port == PORT_A) && w_win_misaligned;
      r_b_gnt    <= w_grant && (w_win_port == PORT_B);
      r_b_err    <= w_grant && (w_win_port == PORT_B) && w_win_misaligned;
      r_a_rvalid <= w_rd_done && (r_cmd_port == PORT_A);
      r_b_rvalid <= w_rd_done && (r_cmd_port == PORT_B);
      if (w_rd_done && (r_cmd_port == PORT_A)) begin
        r_a_rdata <= bus.mem_rd_data;
      end
      if (w_rd_done && (r_cmd_port == PORT_B)) begin
        r_b_rdata <= bus.mem_rd_data;
      end
    end
  end

  assign bus.a_gnt    = r_a_gnt;
  assign bus.a_err    = r_a_err;
  assign bus.a_rvalid = r_a_rvalid;
  assign bus.a_rdata  = r_a_rdata;
  assign bus.b_gnt    = r_b_gnt;
  assign bus.b_err    = r_b_err;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.b_rdata  = r_b_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, scoreboarded bench for dmem_arbiter with a 64-word aliasing memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.RESET_PRIO(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Environment memory: combinational read, write at the clock edge, preload port for setup
  logic [31:0] env_mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;
  assign bus.mem_rd_data = env_mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (pre_we) env_mem[pre_idx] <= pre_data;
    else if (bus.mem_wr_en) env_mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
  end

  // Bench-side reference memory and scoreboards of expected read data
  logic [31:0] model_mem [64];
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    model_mem[idx] = data;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end
  endtask

  // One isolated transaction from IDLE, checking the grant cycle and the response cycle
  task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bit mis;
    bit rd;
    mis = (addr[1:0] != 2'b00);
    rd  = !we && !mis;
    if (rd) begin
      if (port == 1'b0) exp_a_q.push_back(model_mem[addr[7:2]]);
      else              exp_b_q.push_back(model_mem[addr[7:2]]);
    end
    drive(port, 1'b1, we, addr, wdata);
    tick();
    check1("gnt_own",   port ? bus.b_gnt : bus.a_gnt, 1'b1);
    check1("gnt_other", port ? bus.a_gnt : bus.b_gnt, 1'b0);
    check1("err",       port ? bus.b_err : bus.a_err, mis);
    check1("mem_rd_en", bus.mem_rd_en, rd);
    check1("mem_wr_en", bus.mem_wr_en, we && !mis);
    check32("mem_addr", bus.mem_addr, addr);
    tick();
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
    if (we && !mis) model_mem[addr[7:2]] = wdata;
    check1("rvalid", port ? bus.b_rvalid : bus.a_rvalid, rd);
    check1("idle_rd_en", bus.mem_rd_en, 1'b0);
  endtask

  // Response monitor: pops the scoreboard on each rvalid and checks grant exclusivity
  always @(negedge clk) begin
    if (bus.a_gnt || bus.b_gnt) check1("gnt_overlap", bus.a_gnt && bus.b_gnt, 1'b0);
    if (bus.a_rvalid) begin
      if (exp_a_q.size() == 0) check1("a_rvalid_unexpected", bus.a_rvalid, 1'b0);
      else check32("a_rdata", bus.a_rdata, exp_a_q.pop_front());
    end
    if (bus.b_rvalid) begin
      if (exp_b_q.size() == 0) check1("b_rvalid_unexpected", bus.b_rvalid, 1'b0);
      else check32("b_rdata", bus.b_rdata, exp_b_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    preload(6'd1, 32'hA5A5_A5A5);
    preload(6'd3, 32'hDEAD_BEEF);
    preload(6'd4, 32'h0000_0000);
    preload(6'd8, 32'h1111_1111);
    preload(6'd9, 32'h2222_2222);

    // Reset state
    check1("rst_a_gnt", bus.a_gnt, 1'b0);
    check1("rst_b_gnt", bus.b_gnt, 1'b0);
    check1("rst_rd_en", bus.mem_rd_en, 1'b0);
    check32("rst_a_rdata", bus.a_rdata, 32'h0);
    check32("rst_b_rdata", bus.b_rdata, 32'h0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0);
    reset = 1'b0;

    // Single aligned read from port A
    issue(1'b0, 1'b0, 32'h0000_000C, 32'h0);
    check32("a_rdata_read", bus.a_rdata, 32'hDEAD_BEEF);

    // Port B write then read back; port A data untouched
    issue(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check32("b_rdata_wr_rd", bus.b_rdata, 32'h1234_5678);
    check32("a_rdata_kept", bus.a_rdata, 32'hDEAD_BEEF);

    // Misaligned write and read are suppressed
    issue(1'b0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
    check32("mis_mem_kept", env_mem[1], 32'hA5A5_A5A5);
    issue(1'b1, 1'b0, 32'h0000_000D, 32'h0);

    // High address aliases onto word 3
    issue(1'b0, 1'b0, 32'h0000_010C, 32'h0);

    // Continuous dual request from reset release: A,B,A,B
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    exp_a_q.push_back(32'h1111_1111); exp_a_q.push_back(32'h1111_1111);
    exp_b_q.push_back(32'h2222_2222); exp_b_q.push_back(32'h2222_2222);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check1("rr_a_gnt", bus.a_gnt, (i % 4) == 1);
      check1("rr_b_gnt", bus.b_gnt, (i % 4) == 3);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check1("rr_last_rvalid", bus.b_rvalid, 1'b1);
    check32("idle_mem_addr_hold", bus.mem_addr, 32'h0000_0024);

    // Loser drops its request before grant: pointer moves only for the winner
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    exp_a_q.push_back(32'h1111_1111);
    tick();
    check1("drop_a_gnt", bus.a_gnt, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check1("drop_no_b_gnt", bus.b_gnt, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    exp_b_q.push_back(32'h2222_2222);
    tick();
    check1("after_drop_b_gnt", bus.b_gnt, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset during B's read ACCESS abandons it
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    tick();
    check1("rst_mid_b_gnt", bus.b_gnt, 1'b1);
    reset = 1'b1;
    #1;
    check1("rst_mid_rd_en", bus.mem_rd_en, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    check1("rst_mid_no_rvalid", bus.b_rvalid, 1'b0);
    check32("rst_mid_b_rdata", bus.b_rdata, 32'h0);
    tick();
    check1("rst_mid_idle", bus.b_rvalid, 1'b0);

    // Priority returns to RESET_PRIO after reset even if it pointed at B
    issue(1'b0, 1'b0, 32'h0000_0020, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    exp_a_q.push_back(32'h1111_1111);
    tick();
    check1("post_rst_prio_a", bus.a_gnt, 1'b1);
    check1("post_rst_prio_b", bus.b_gnt, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    check32("a_queue_drained", 32'(exp_a_q.size()), 32'h0);
    check32("b_queue_drained", 32'(exp_b_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: RESET_PRIO, 0, port holding round-robin priority after reset (0 = port A, 1 = port B).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 a_req  in  1  port A request; a_we, a_addr, a_wdata held stable while a_req=1 and a_gnt=0.
REQ-006 a_we  in  1  port A write (1) / read (0).
REQ-007 a_addr  in  32  port A byte address.
REQ-008 a_wdata  in  32  port A write data.
REQ-009 a_gnt  out  1  one-cycle pulse: port A command is executing this cycle.
REQ-010 a_err  out  1  one-cycle pulse coincident with a_gnt: command was misaligned and suppressed.
REQ-011 a_rvalid  out  1  one-cycle pulse: a_rdata holds port A read result.
REQ-012 a_rdata  out  32  port A read data, held until the next port A read response.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_err, b_rvalid, b_rdata: port B, identical to REQ-005..REQ-012.
REQ-014 mem_addr  out  32  address to the data memory.
REQ-015 mem_rd_en  out  1  data memory read enable.
REQ-016 mem_wr_en  out  1  data memory write enable.
REQ-017 mem_wr_data  out  32  data memory write data.
REQ-018 mem_rd_data  in  32  data memory read data, combinational from mem_addr.

Function
REQ-019 FSM states: IDLE, ACCESS; IDLE -> ACCESS when a_req|b_req sampled high; ACCESS -> IDLE unconditionally; IDLE stays IDLE with no request.
REQ-020 On the IDLE->ACCESS edge, the winner's we/addr/wdata and port id are latched into command registers.
REQ-021 Winner: single requester wins; both requesting -> port holding priority wins.
REQ-022 Priority pointer updates on each grant to the port not granted; unchanged in cycles without a grant.
REQ-023 x_gnt = 1 exactly during the ACCESS cycle serving port x; never both gnt high.
REQ-024 During ACCESS: mem_addr = latched addr; mem_wr_data = latched wdata; mem_wr_en = latched we; mem_rd_en = ~latched we.
REQ-025 Misaligned (latched addr[1:0] != 0): mem_rd_en = mem_wr_en = 0 in ACCESS; x_err = 1 with x_gnt; no x_rvalid.
REQ-026 No address range check; addresses pass unchanged (memory aliases above its depth).
REQ-027 Aligned read: mem_rd_data captured into x_rdata at the end of ACCESS; x_rvalid = 1 the following cycle (read latency: 2 cycles from request sampling edge).
REQ-028 Writes produce no rvalid; x_gnt is write completion; memory updated at the end of the ACCESS cycle.
REQ-029 Outside ACCESS: mem_rd_en = mem_wr_en = 0; mem_addr/mem_wr_data hold last latched values.
REQ-030 Requester may change or drop its command only at the edge ending its gnt cycle; a still-high req is re-sampled in the next IDLE as a new transaction.
REQ-031 Throughput: one transaction per 2 cycles; under continuous dual request grants alternate A,B,A,B...
REQ-032 Request dropped before grant: no transaction, no pointer change.

Reset
REQ-033 reset sampled high: state = IDLE, priority = RESET_PRIO, command registers = 0, all gnt/err/rvalid = 0, a_rdata = b_rdata = 0.
REQ-034 mem_rd_en and mem_wr_en SHALL be 0 combinationally in any cycle where reset = 1, including reset asserted during ACCESS.
REQ-035 Reset during ACCESS abandons the transaction: no rvalid issued afterward; pending read result discarded.

Verification
REQ-036 Single read: mem word 3 = 0xDEADBEEF, a_req, a_we=0, a_addr=0x0C -> a_gnt next cycle with mem_rd_en=1, mem_addr=0x0C; a_rvalid following cycle, a_rdata = 0xDEADBEEF.
REQ-037 Contention: RESET_PRIO=0, a_req and b_req held high from reset release -> grant sequence A,B,A,B, one gnt per 2 cycles, never overlapping.
REQ-038 Write then read: b writes 0x12345678 to 0x10, then reads 0x10 -> b_rvalid with b_rdata = 0x12345678; a_rdata unchanged.
REQ-039 Misaligned: a_req, a_we=1, a_addr=0x06 -> a_gnt and a_err together, mem_wr_en=0, memory unchanged, no a_rvalid.
REQ-040 Reset mid-access: reset asserted in B's read ACCESS cycle -> mem enables 0 that cycle, no b_rvalid, state IDLE, next dual request granted to RESET_PRIO port.
